// File: rtl/accumulator_core_pkg.sv
// Shared definitions for the accumulator core: opcodes, FSM states, default widths.
package accumulator_core_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OP_WIDTH   = 4;
  localparam int DEF_PC_WIDTH   = 4;
  localparam int DEF_NUM_REGS   = 4;

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_LDI  = 4'h1,
    OPC_LD   = 4'h2,
    OPC_ST   = 4'h3,
    OPC_ADDI = 4'h4,
    OPC_ADD  = 4'h5,
    OPC_SUB  = 4'h6,
    OPC_AND  = 4'h7,
    OPC_OR   = 4'h8,
    OPC_XOR  = 4'h9,
    OPC_JMP  = 4'hA,
    OPC_JZ   = 4'hB,
    OPC_JC   = 4'hC,
    OPC_OUT  = 4'hD,
    OPC_SRST = 4'hE,
    OPC_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_OUT = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

endpackage

// File: rtl/accumulator_core_if.sv
// Program-ROM fetch path plus the ready/valid output port of the core.
interface accumulator_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4,
  parameter int PC_WIDTH   = 4
);
  localparam int ROM_WIDTH = OP_WIDTH + DATA_WIDTH;

  logic [PC_WIDTH-1:0]   PC;
  logic [ROM_WIDTH-1:0]  INSTR;
  logic [DATA_WIDTH-1:0] OUT_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;

  // core side
  modport master (
    output PC, OUT_DATA, OUT_VALID,
    input  INSTR, OUT_READY
  );

  // ROM + consumer side
  modport slave (
    input  PC, OUT_DATA, OUT_VALID,
    output INSTR, OUT_READY
  );
endinterface

// File: rtl/accumulator_core_alu.sv
// Combinational ALU: add/sub with carry-borrow, bitwise ops, operand pass-through.
module core_alu
  import accumulator_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  opcode_t               op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  // Function select; anything not arithmetic/logic passes b (load paths) or a.
  always_comb begin
    result = a;
    carry  = 1'b0;
    unique case (op)
      OPC_ADD, OPC_ADDI: {carry, result} = {1'b0, a} + {1'b0, b};
      OPC_SUB:           {carry, result} = {1'b0, a} - {1'b0, b};
      OPC_AND:           result = a & b;
      OPC_OR:            result = a | b;
      OPC_XOR:           result = a ^ b;
      OPC_LDI, OPC_LD:   result = b;
      default:           result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/accumulator_core.sv
// Single-cycle accumulator CPU: PC, decode, ACC, register file, Z/C flags,
// branches, ready/valid OUT port and HALT state.
module accumulator_core
  import accumulator_core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH,
  parameter int PC_WIDTH   = DEF_PC_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  accumulator_core_if.master    bus,
  output logic                  HALTED,
  output logic [DATA_WIDTH-1:0] ACC_OUT,
  output logic                  FLAG_Z,
  output logic                  FLAG_C
);

  localparam int ROM_WIDTH = OP_WIDTH + DATA_WIDTH;
  localparam int RSEL_W    = $clog2(NUM_REGS);

  state_t                               state;
  logic [PC_WIDTH-1:0]                  pc_q;
  logic [DATA_WIDTH-1:0]                acc_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
  logic                                 z_q, c_q;
  logic [DATA_WIDTH-1:0]                out_data_q;
  logic                                 out_valid_q;
  logic                                 halted_q;

  logic [OP_WIDTH-1:0]   op_raw;
  logic [DATA_WIDTH-1:0] imm;
  logic [RSEL_W-1:0]     rsel;
  logic [PC_WIDTH-1:0]   tgt;
  logic [PC_WIDTH-1:0]   pc_inc;
  opcode_t               opc;
  logic [DATA_WIDTH-1:0] alu_b, alu_res;
  logic                  alu_c, alu_z;

  assign op_raw = bus.INSTR[ROM_WIDTH-1:DATA_WIDTH];
  assign imm    = bus.INSTR[DATA_WIDTH-1:0];
  assign rsel   = imm[RSEL_W-1:0];
  assign tgt    = imm[PC_WIDTH-1:0];
  assign pc_inc = pc_q + 1'b1;

  // Opcodes with any bit set above the low nibble decode as NOP.
  always_comb begin
    opc = opcode_t'(op_raw[3:0]);
    if ((op_raw >> 4) != '0) opc = OPC_NOP;
  end

  // Immediate forms feed imm, register forms feed R[rsel].
  always_comb begin
    alu_b = regs[rsel];
    if (opc == OPC_LDI || opc == OPC_ADDI) alu_b = imm;
  end

  core_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a      (acc_q),
    .b      (alu_b),
    .op     (opc),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Execute FSM: architectural state only changes in RUN; WAIT_OUT and HALT freeze it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_RUN;
      pc_q        <= '0;
      acc_q       <= '0;
      regs        <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          pc_q <= pc_inc;
          unique case (opc)
            OPC_LDI, OPC_LD: acc_q <= alu_res;
            OPC_ST:          regs[rsel] <= acc_q;
            OPC_ADDI, OPC_ADD, OPC_SUB: begin
              acc_q <= alu_res;
              z_q   <= alu_z;
              c_q   <= alu_c;
            end
            OPC_AND, OPC_OR, OPC_XOR: begin
              acc_q <= alu_res;
              z_q   <= alu_z;
              c_q   <= 1'b0;
            end
            OPC_JMP:  pc_q <= tgt;
            OPC_JZ:   if (z_q) pc_q <= tgt;
            OPC_JC:   if (c_q) pc_q <= tgt;
            OPC_OUT: begin
              // PC stays on the OUT until the consumer takes the data.
              pc_q        <= pc_q;
              out_data_q  <= acc_q;
              out_valid_q <= 1'b1;
              state       <= ST_WAIT_OUT;
            end
            OPC_SRST: pc_q <= '0;
            OPC_HALT: begin
              pc_q     <= pc_q;
              halted_q <= 1'b1;
              state    <= ST_HALT;
            end
            default: ;
          endcase
        end
        ST_WAIT_OUT: begin
          if (bus.OUT_READY) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc;
            state       <= ST_RUN;
          end
        end
        default: ;  // ST_HALT: only reset leaves
      endcase
    end
  end

  assign bus.PC        = pc_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VALID = out_valid_q;
  assign HALTED        = halted_q;
  assign ACC_OUT       = acc_q;
  assign FLAG_Z        = z_q;
  assign FLAG_C        = c_q;

endmodule

// File: tb/tb_accumulator_core.sv
// Directed-program bench for accumulator_core with an OUT-port scoreboard.
module tb_accumulator_core;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic       HALTED;
  logic [7:0] ACC_OUT;
  logic       FLAG_Z, FLAG_C;

  logic [11:0] rom [16];
  logic [7:0]  exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  accumulator_core_if #(.DATA_WIDTH(8), .OP_WIDTH(4), .PC_WIDTH(4)) bus ();

  assign bus.INSTR = rom[bus.PC];

  accumulator_core #(.DATA_WIDTH(8), .OP_WIDTH(4), .PC_WIDTH(4), .NUM_REGS(4)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .bus     (bus),
    .HALTED  (HALTED),
    .ACC_OUT (ACC_OUT),
    .FLAG_Z  (FLAG_Z),
    .FLAG_C  (FLAG_C)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge CLK) begin
    if (RST_N && bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0h expected none", bus.OUT_DATA);
      end else begin
        chk("out_data", {24'd0, bus.OUT_DATA}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.OUT_READY = 1'b1;
    clear_rom();

    // reset state
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", {28'd0, bus.PC}, 0);
    chk("rst_acc", {24'd0, ACC_OUT}, 0);
    chk("rst_valid", {31'd0, bus.OUT_VALID}, 0);
    chk("rst_data", {24'd0, bus.OUT_DATA}, 0);
    chk("rst_halt", {31'd0, HALTED}, 0);
    chk("rst_flags", {30'd0, FLAG_Z, FLAG_C}, 0);

    // program 1: arithmetic, flags, OUT, HALT
    clear_rom();
    rom[0] = 12'h1F0; rom[1] = 12'h301; rom[2] = 12'h120; rom[3] = 12'h501;
    rom[4] = 12'h601; rom[5] = 12'h105; rom[6] = 12'h302; rom[7] = 12'h602;
    rom[8] = 12'hD00; rom[9] = 12'hF00;
    do_reset();
    exp_q.push_back(8'h00);
    edges(4);
    chk("add_acc", {24'd0, ACC_OUT}, 32'h10);
    chk("add_zc", {30'd0, FLAG_Z, FLAG_C}, 2'b01);
    edges(1);
    chk("sub_acc", {24'd0, ACC_OUT}, 32'h20);
    chk("sub_zc", {30'd0, FLAG_Z, FLAG_C}, 2'b01);
    edges(3);
    chk("sub0_acc", {24'd0, ACC_OUT}, 0);
    chk("sub0_zc", {30'd0, FLAG_Z, FLAG_C}, 2'b10);
    edges(1);
    chk("out1_valid", {31'd0, bus.OUT_VALID}, 1);
    chk("out1_pc", {28'd0, bus.PC}, 8);
    edges(1);
    chk("out1_done", {31'd0, bus.OUT_VALID}, 0);
    chk("out1_pc_adv", {28'd0, bus.PC}, 9);
    edges(1);
    chk("halt_flag", {31'd0, HALTED}, 1);
    rom[9] = 12'h1FF;
    edges(10);
    chk("halt_pc", {28'd0, bus.PC}, 9);
    chk("halt_acc", {24'd0, ACC_OUT}, 0);
    chk("halt_hold", {31'd0, HALTED}, 1);

    // program 2: branches, OUT back-pressure, SRST
    clear_rom();
    rom[0]  = 12'h100; rom[1]  = 12'h400; rom[2]  = 12'hB09;
    rom[9]  = 12'h401; rom[10] = 12'hB00; rom[11] = 12'h15A; rom[12] = 12'hD00;
    rom[13] = 12'h133; rom[14] = 12'hA06; rom[6]  = 12'hE00;
    do_reset();
    chk("unhalt", {31'd0, HALTED}, 0);
    chk("unhalt_pc", {28'd0, bus.PC}, 0);
    edges(3);
    chk("jz_taken_pc", {28'd0, bus.PC}, 9);
    edges(2);
    chk("jz_not_pc", {28'd0, bus.PC}, 11);
    chk("addi1_z", {31'd0, FLAG_Z}, 0);
    bus.OUT_READY = 1'b0;
    edges(2);
    chk("wait_valid", {31'd0, bus.OUT_VALID}, 1);
    chk("wait_data", {24'd0, bus.OUT_DATA}, 32'h5A);
    edges(2);
    chk("wait_pc", {28'd0, bus.PC}, 12);
    chk("wait_valid2", {31'd0, bus.OUT_VALID}, 1);
    chk("wait_data2", {24'd0, bus.OUT_DATA}, 32'h5A);
    exp_q.push_back(8'h5A);
    bus.OUT_READY = 1'b1;
    edges(1);
    chk("acc_valid", {31'd0, bus.OUT_VALID}, 0);
    chk("acc_pc", {28'd0, bus.PC}, 13);
    edges(3);
    chk("srst_pc", {28'd0, bus.PC}, 0);
    chk("srst_acc", {24'd0, ACC_OUT}, 32'h33);

    // program 3: register-select wrap, JC, XOR, PC wrap, async reset
    clear_rom();
    rom[0]  = 12'h177; rom[1]  = 12'h306; rom[2] = 12'h100; rom[3] = 12'h202;
    rom[4]  = 12'hD00; rom[5]  = 12'h4FF; rom[6] = 12'hC0D;
    rom[13] = 12'h902; rom[14] = 12'hA0F; rom[15] = 12'h000;
    do_reset();
    exp_q.push_back(8'h77);
    edges(5);
    chk("ld_wrap_out", {24'd0, bus.OUT_DATA}, 32'h77);
    edges(1);
    chk("out3_pc", {28'd0, bus.PC}, 5);
    edges(1);
    chk("addi_c_acc", {24'd0, ACC_OUT}, 32'h76);
    chk("addi_c_zc", {30'd0, FLAG_Z, FLAG_C}, 2'b01);
    edges(1);
    chk("jc_pc", {28'd0, bus.PC}, 13);
    edges(1);
    chk("xor_acc", {24'd0, ACC_OUT}, 32'h01);
    chk("xor_zc", {30'd0, FLAG_Z, FLAG_C}, 2'b00);
    edges(1);
    chk("jmp_f_pc", {28'd0, bus.PC}, 15);
    edges(1);
    chk("wrap_pc", {28'd0, bus.PC}, 0);
    edges(2);
    chk("pre_arst_acc", {24'd0, ACC_OUT}, 32'h77);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_pc", {28'd0, bus.PC}, 0);
    chk("arst_acc", {24'd0, ACC_OUT}, 0);
    edges(1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulator_core.md
Name: accumulator_core

Overview:
Parametrised successor of the PC/ROM/decoder/ALU/ACC/R0 datapath. Integrates into one block the program counter, instruction decoder, ALU, accumulator, an N-entry register file, Z/C flags, conditional branches and a halt state. Also provides a ready/valid output port that stalls execution until a consumer accepts the data. Fetches from an external combinational program ROM (rom16x8-style) through PC/INSTR.

Parameters:
DATA_WIDTH, 8, width of ACC, registers, immediate and OUT_DATA
OP_WIDTH, 4, opcode field width (INSTR[ROM_WIDTH-1:DATA_WIDTH])
PC_WIDTH, 4, program counter width; program depth 2**PC_WIDTH
NUM_REGS, 4, register-file entries, power of two >= 2
ROM_WIDTH, OP_WIDTH+DATA_WIDTH (localparam), instruction width

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
PC  output  PC_WIDTH  ROM address of current instruction
INSTR  input  ROM_WIDTH  instruction at PC: opcode in the upper bits, immediate in the lower bits
OUT_DATA  output  DATA_WIDTH  output port data
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  consumer accepts OUT_DATA
HALTED  output  1  core stopped on HALT
ACC_OUT  output  DATA_WIDTH  accumulator value, for debug/observation
FLAG_Z  output  1  zero flag
FLAG_C  output  1  carry/borrow flag

Behaviour:
- Reset (RST_N low, async): PC=0, ACC=0, all registers=0, Z=C=0, OUT_DATA=0, OUT_VALID=0, HALTED=0, state=RUN. Reset mid-OUT or mid-HALT returns to RUN immediately.
- States: RUN, WAIT_OUT, HALT.
- RUN: single-cycle execution. INSTR is decoded combinationally and the result is committed on the next CLK edge. The default next PC is PC+1, wrapping from 2**PC_WIDTH-1 to 0.
- Operand fields: imm = INSTR[DATA_WIDTH-1:0]; rsel = imm[log2(NUM_REGS)-1:0], with upper bits ignored; jump target = imm[PC_WIDTH-1:0].
- Opcodes:
  - 0 NOP
  - 1 LDI: ACC=imm
  - 2 LD: ACC=R[rsel]
  - 3 ST: R[rsel]=ACC
  - 4 ADDI: ACC=ACC+imm
  - 5 ADD: ACC=ACC+R[rsel]
  - 6 SUB: ACC=ACC-R[rsel]
  - 7 AND, 8 OR, 9 XOR: ACC op R[rsel]
  - A JMP
  - B JZ: jump if Z
  - C JC: jump if C
  - D OUT
  - E SRST: PC=0; ACC, registers and flags are kept (replaces the old RST_CODE path)
  - F HALT
  - Opcodes beyond F, if OP_WIDTH>4, behave as NOP.
- Arithmetic: DATA_WIDTH-bit modulo. ADD/ADDI set C = carry out. SUB sets C = borrow (ACC < R[rsel]). Each of these sets Z = (result==0).
- Logic ops set Z and clear C. LDI, LD, ST, jumps and OUT leave the flags unchanged.
- Branches use the flag values from before the current instruction. A taken branch sets PC=target; a not-taken branch sets PC=PC+1.
- OUT from RUN:
  - At the edge: OUT_DATA<=ACC, OUT_VALID<=1, PC held, state<=WAIT_OUT.
  - In WAIT_OUT the core executes nothing. OUT_DATA and OUT_VALID stay stable.
  - At the edge where OUT_READY=1: OUT_VALID<=0, PC<=PC+1, state<=RUN.
  - Minimum OUT latency is 2 cycles. A subsequent OUT in the next RUN cycle is legal.
  - OUT_READY is ignored outside WAIT_OUT.
- HALT: at the edge, HALTED<=1 and state<=HALT. PC, ACC and the registers are frozen. Only RST_N leaves this state.
- The register file, ACC and flags are written only in RUN.

Decomposition:
- Shared package/include core_defs.vh:
  - opcode localparams (OPC_NOP..OPC_HALT)
  - state encodings (ST_RUN, ST_WAIT_OUT, ST_HALT)
  - default widths
- One sub-module: core_alu. It is combinational and takes (a, b, opcode), returning result, carry and zero.
- The PC, state machine and register file stay in accumulator_core.

Test Plan:
- Reset: RST_N low for 2 cycles, then high -> PC=0, ACC_OUT=0, OUT_VALID=0, HALTED=0. Assert RST_N low asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Arithmetic/flags:
  - Program LDI 0xF0; ST R1; LDI 0x20; ADD R1 -> ACC=0x10, C=1, Z=0.
  - Then SUB R1 (0x10-0xF0) -> ACC=0x20, C=1 (borrow), Z=0.
  - LDI 0x05; ST R2; SUB R2 -> ACC=0x00, Z=1, C=0.
- Branching: LDI 0; ADDI 0 (sets Z=1); JZ 0x9 -> PC=9 next cycle. With Z=0, JZ 0x9 -> PC=PC+1. JMP 0xF followed by NOP at 0xF -> PC wraps to 0.
- OUT handshake: LDI 0x5A; OUT with OUT_READY held low 3 cycles -> OUT_VALID=1, OUT_DATA=0x5A, PC frozen at the OUT address. OUT_READY high for 1 cycle -> OUT_VALID=0 and PC advances by 1 on that edge.
- HALT and SRST:
  - SRST at address 6 with ACC=0x33 -> PC=0, ACC stays 0x33.
  - HALT -> HALTED=1; PC/ACC unchanged for 10 cycles regardless of INSTR.
  - RST_N pulse -> HALTED=0, PC=0.
- Register select wrap: NUM_REGS=4, ST with imm=0x06 -> writes R2. LD with imm=0x02 -> returns the same value.
